// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the IF/ID stage.
// Handshake: an instruction at the fetch-buffer head is offered while out_valid
// is high; it is consumed on a rising edge where out_valid=1, stall=0 and
// redirect_valid=0 (stall acts as an inverted ready). imem_req has no ready:
// memory always accepts and returns imem_instr exactly one cycle later.
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              stall;
  logic              out_valid;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc4;

  // fetch unit side
  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4,
    input  imem_instr, redirect_valid, redirect_pc, stall
  );

  // memory / pipeline / hazard-unit side
  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4,
    output imem_instr, redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the PC, issues one-cycle-latency
// instruction memory reads and buffers {pc, instr} pairs in a small FIFO ahead
// of IF/ID. Redirects flush everything and reload the PC; stalls only block pop.
// Optional feature macro FETCH_BYPASS_EN: a response arriving at an empty FIFO
// is shown on out_* combinationally (and not pushed when it is popped at once).
module fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] fifo_pc_q    [DEPTH];
  logic [31:0]       fifo_instr_q [DEPTH];

  logic          fifo_empty;
  logic          resp_valid;
  logic          bypass_show;
  logic          out_valid;
  logic          pop;
  logic          pop_fifo;
  logic          push;
  logic          issue;
  logic [OW-1:0] occupancy;

  // Handshake decode: response acceptance, pop, push and issue decisions
  always_comb begin
    fifo_empty = (count_q == '0);
    resp_valid = inflight_q & ~bus.redirect_valid;
`ifdef FETCH_BYPASS_EN
    bypass_show = fifo_empty & resp_valid;
`else
    bypass_show = 1'b0;
`endif
    out_valid = ~fifo_empty | bypass_show;
    pop       = out_valid & ~bus.stall & ~bus.redirect_valid;
    pop_fifo  = pop & ~fifo_empty;
    // a bypassed response that is consumed this cycle never enters the FIFO
    push      = resp_valid & ~(bypass_show & ~bus.stall);
    // slots committed after this cycle: buffered + in flight - leaving now
    occupancy = {1'b0, count_q} + OW'(inflight_q) - OW'(pop);
    issue     = rst_n & ~bus.redirect_valid & (occupancy < OW'(DEPTH));
  end

  // Next-state for PC, in-flight tracking, pointers and count
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d          = pc_q + ADDR_W'(4);
        inflight_pc_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_fifo) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop_fifo) count_d = count_q + CW'(1);
      else if (!push && pop_fifo) count_d = count_q - CW'(1);
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage write; contents are don't-care while count says empty
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
      fifo_instr_q[wr_ptr_q] <= bus.imem_instr;
    end
  end

  // Output drive: FIFO head, bypassed response, or zeros when nothing valid
  always_comb begin
    bus.imem_req  = issue;
    bus.imem_addr = pc_q;
    bus.out_valid = out_valid;
    bus.out_instr = '0;
    bus.out_pc    = '0;
    if (!fifo_empty) begin
      bus.out_instr = fifo_instr_q[rd_ptr_q];
      bus.out_pc    = fifo_pc_q[rd_ptr_q];
    end else if (bypass_show) begin
      bus.out_instr = bus.imem_instr;
      bus.out_pc    = inflight_pc_q;
    end
    bus.out_pc4 = bus.out_pc + ADDR_W'(4);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset values, start-up latency, steady stream,
// stall/release, redirect with full buffer, redirect racing a response, PC
// wrap, and mid-stream reset. Instruction memory is a one-cycle-latency model.
module tb_fetch_unit;
  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] exp_q[$];

  fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .DEPTH(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // instruction memory: word for the accepted address appears next cycle
  always @(posedge clk) begin
    if (bus.imem_req === 1'b1) bus.imem_instr <= instr_of(bus.imem_addr);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick();
    tick();
    rst_n = 1'b1;   // current cycle is cycle 0 after release
  endtask

  task automatic wait_out_pc(input logic [31:0] target, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_pc === target) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    tick();
    @(negedge clk);
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", bus.imem_req); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rst_addr got %h exp %h", bus.imem_addr, RESET_PC); end
    n_checks++; if (bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp 0", bus.out_instr); end
    n_checks++; if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", bus.out_pc); end
    n_checks++; if (bus.out_pc4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc4 got %h exp 4", bus.out_pc4); end
  endtask

  task automatic test_startup_stream();
    logic exp_v;
    logic [31:0] e;
    do_reset();
    for (int c = 0; c <= LAT; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
          n_fail++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
        end
      end
      exp_v = (c == LAT);
      n_checks++;
      if (bus.out_valid !== exp_v) begin n_fail++; $display("FAIL startup_valid c=%0d got %b exp %b", c, bus.out_valid, exp_v); end
      if (c < LAT) tick();
    end
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin tick(); @(negedge clk); end
      e = exp_q.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== e) begin
        n_fail++; $display("FAIL stream_pc k=%0d got v=%b pc=%h exp pc=%h", k, bus.out_valid, bus.out_pc, e);
      end
      n_checks++;
      if (bus.out_instr !== instr_of(e)) begin n_fail++; $display("FAIL stream_instr k=%0d got %h exp %h", k, bus.out_instr, instr_of(e)); end
      n_checks++;
      if (bus.out_pc4 !== e + 32'd4) begin n_fail++; $display("FAIL stream_pc4 k=%0d got %h exp %h", k, bus.out_pc4, e + 32'd4); end
    end
  endtask

  task automatic test_stall();
    bit found;
    logic [31:0] e;
    do_reset();
    wait_out_pc(32'h8, found);
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL stall_reach_pc8 got none exp out_pc=8"); return; end
    bus.stall = 1'b1;
    #1;
    for (int s = 1; s <= 5; s++) begin
      if (s > 1) begin tick(); @(negedge clk); end
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h8) begin
        n_fail++; $display("FAIL stall_hold s=%0d got v=%b pc=%h exp pc=8", s, bus.out_valid, bus.out_pc);
      end
      if (s >= 3) begin
        n_checks++;
        if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req s=%0d got %b exp 0", s, bus.imem_req); end
      end
    end
    tick();
    bus.stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = 32'h8 + 32'(4 * k);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== e) begin
        n_fail++; $display("FAIL stall_release k=%0d got v=%b pc=%h exp pc=%h", k, bus.out_valid, bus.out_pc, e);
      end
      if (k < 2) tick();
    end
  endtask

  // After a redirect in cycle R: fetch of target in R+1, target shown in R+1+LAT
  task automatic check_redirect_target(input logic [31:0] target, input string tag);
    logic exp_v;
    @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== target) begin
      n_fail++; $display("FAIL %s_refetch got req=%b addr=%h exp req=1 addr=%h", tag, bus.imem_req, bus.imem_addr, target);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_flush got out_valid=%b exp 0", tag, bus.out_valid); end
    for (int c = 2; c <= 1 + LAT; c++) begin
      tick(); @(negedge clk);
      exp_v = (c == 1 + LAT);
      n_checks++;
      if (bus.out_valid !== exp_v) begin n_fail++; $display("FAIL %s_valid c=%0d got %b exp %b", tag, c, bus.out_valid, exp_v); end
    end
    n_checks++;
    if (bus.out_pc !== target || bus.out_instr !== instr_of(target)) begin
      n_fail++; $display("FAIL %s_target got pc=%h instr=%h exp pc=%h instr=%h", tag, bus.out_pc, bus.out_instr, target, instr_of(target));
    end
    tick(); @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== target + 32'd4) begin
      n_fail++; $display("FAIL %s_next got v=%b pc=%h exp pc=%h", tag, bus.out_valid, bus.out_pc, target + 32'd4);
    end
  endtask

  task automatic test_redirect_full();
    bit found;
    do_reset();
    wait_out_pc(32'h4, found);
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL redir_reach_pc4 got none exp out_pc=4"); return; end
    bus.stall = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_full_req got %b exp 0", bus.imem_req); end
    tick();
    bus.stall = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0102;
    @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_cycle_req got %b exp 0", bus.imem_req); end
    tick();
    bus.redirect_valid = 1'b0;
    check_redirect_target(32'h0000_0100, "redir_full");
  endtask

  task automatic test_redirect_resp();
    do_reset();
    tick();   // cycle 1: response for RESET_PC arriving
    bus.redirect_valid = 1'b1; bus.stall = 1'b1; bus.redirect_pc = 32'h0000_0040;
    @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_resp_req got %b exp 0", bus.imem_req); end
    tick();
    bus.redirect_valid = 1'b0; bus.stall = 1'b0;
    check_redirect_target(32'h0000_0040, "redir_resp");
  endtask

  task automatic test_wrap();
    bit found;
    logic [31:0] e;
    do_reset();
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    wait_out_pc(32'hFFFF_FFF8, found);
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL wrap_reach got none exp out_pc=fffffff8"); return; end
    for (int k = 1; k <= 3; k++) begin
      tick(); @(negedge clk);
      e = 32'hFFFF_FFF8 + 32'(4 * k);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== e) begin
        n_fail++; $display("FAIL wrap_pc k=%0d got v=%b pc=%h exp pc=%h", k, bus.out_valid, bus.out_pc, e);
      end
      if (k == 1) begin
        n_checks++;
        if (bus.out_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got %h exp 0", bus.out_pc4); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    logic exp_v;
    do_reset();
    wait_out_pc(32'hC, found);
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rmid_reach got none exp out_pc=c"); return; end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_low got %b exp 0", bus.imem_req); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", bus.out_valid); end
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL rmid_refetch got req=%b addr=%h exp req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC);
    end
    for (int c = 1; c <= LAT; c++) begin
      tick(); @(negedge clk);
      exp_v = (c == LAT);
      n_checks++;
      if (bus.out_valid !== exp_v) begin n_fail++; $display("FAIL rmid_lat c=%0d got %b exp %b", c, bus.out_valid, exp_v); end
    end
    n_checks++;
    if (bus.out_pc !== RESET_PC) begin n_fail++; $display("FAIL rmid_pc got %h exp %h", bus.out_pc, RESET_PC); end
  endtask

  initial begin
    test_reset();
    test_startup_stream();
    test_stall();
    test_redirect_full();
    test_redirect_resp();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
